fir_seq_mac: RTL and testbench

//  Parametrised N-tap signed FIR filter sitting between AdcReader and DacWriter, clocked by the
//  50 MHz system clock and advanced once per sample strobe (TickGen tick).
//  One multiplier, time-shared: a MAC state machine walks all taps after each sample.

---
 rtl/fir_seq_mac_if.sv | 31 +++
 rtl/fir_seq_mac.sv | 165 ++++++++++++++++
 tb/tb_fir_seq_mac.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_mac_if.sv
// Sample/coefficient bus between the sample source and the sequential FIR.
// Master drives strobes and coefficient writes; slave returns the filtered sample.
interface fir_seq_mac_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8
);
    localparam int unsigned AW = $clog2(TAPS);

    logic                     start_i;
    logic signed [DATA_W-1:0] data_i;
    logic [1:0]               mode_i;
    logic                     coef_we_i;
    logic [AW-1:0]            coef_addr_i;
    logic signed [COEF_W-1:0] coef_i;
    logic signed [DATA_W-1:0] data_o;
    logic                     valid_o;
    logic                     busy_o;
    logic                     sat_o;
    logic                     overrun_o;

    modport master (
        output start_i, data_i, mode_i, coef_we_i, coef_addr_i, coef_i,
        input  data_o, valid_o, busy_o, sat_o, overrun_o
    );

    modport slave (
        input  start_i, data_i, mode_i, coef_we_i, coef_addr_i, coef_i,
        output data_o, valid_o, busy_o, sat_o, overrun_o
    );
endinterface

// File: rtl/fir_seq_mac.sv
// N-tap signed FIR with one time-shared multiplier; a MAC sequencer walks all taps per sample.
// Zero / bypass / filter output modes, round-half-up and saturation on the filtered result.
module fir_seq_mac #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned FRAC   = 15,
    parameter int unsigned ACC_W  = 40
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    fir_seq_mac_if.slave  bus
);
    localparam int unsigned AW     = $clog2(TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST_K = AW'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] RND_V = ACC_W'(1) << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MAC,
        S_OUT
    } state_t;

    state_t                   state_q;
    logic signed [DATA_W-1:0] hist_q [TAPS];
    logic signed [COEF_W-1:0] coef_q [TAPS];
    logic [AW-1:0]            wp_q;
    logic [AW-1:0]            k_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [1:0]               mode_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] res_q;
    logic                     res_sat_q;
    logic                     res_vld_q;
    logic signed [DATA_W-1:0] data_o_q;
    logic                     valid_o_q;
    logic                     busy_o_q;
    logic                     sat_o_q;
    logic                     overrun_o_q;

    logic [AW-1:0]            rd_idx_d;
    logic signed [PROD_W-1:0] prod_d;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  rnd_d;
    logic signed [DATA_W-1:0] res_d;
    logic                     res_sat_d;

    // x[n-k] lives at (wp - k) mod TAPS
    always_comb begin
        if (wp_q >= k_q) begin
            rd_idx_d = wp_q - k_q;
        end else begin
            rd_idx_d = AW'(32'(wp_q) + TAPS - 32'(k_q));
        end
    end

    always_comb begin
        prod_d = PROD_W'(hist_q[rd_idx_d]) * PROD_W'(coef_q[k_q]);
        acc_d  = acc_q + ACC_W'(prod_d);
        rnd_d  = (acc_q + RND_V) >>> FRAC;
    end

    // Result select with clamping in filter mode only
    always_comb begin
        res_d     = '0;
        res_sat_d = 1'b0;
        if (mode_q[1]) begin
            if (rnd_d > MAX_V) begin
                res_d     = MAX_V[DATA_W-1:0];
                res_sat_d = 1'b1;
            end else if (rnd_d < MIN_V) begin
                res_d     = MIN_V[DATA_W-1:0];
                res_sat_d = 1'b1;
            end else begin
                res_d     = rnd_d[DATA_W-1:0];
            end
        end else if (mode_q[0]) begin
            res_d = x_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < int'(TAPS); i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
            wp_q        <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            mode_q      <= '0;
            x_q         <= '0;
            res_q       <= '0;
            res_sat_q   <= 1'b0;
            res_vld_q   <= 1'b0;
            data_o_q    <= '0;
            valid_o_q   <= 1'b0;
            busy_o_q    <= 1'b0;
            sat_o_q     <= 1'b0;
            overrun_o_q <= 1'b0;
        end else begin
            valid_o_q <= 1'b0;
            res_vld_q <= 1'b0;

            if (bus.start_i && busy_o_q) begin
                overrun_o_q <= 1'b1;
            end
            if (bus.coef_we_i && !busy_o_q && (32'(bus.coef_addr_i) < TAPS)) begin
                coef_q[bus.coef_addr_i] <= bus.coef_i;
            end

            // Output register stage behind the rounding/saturation logic
            if (res_vld_q) begin
                data_o_q  <= res_q;
                sat_o_q   <= res_sat_q;
                valid_o_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        hist_q[wp_q] <= bus.data_i;
                        x_q          <= bus.data_i;
                        mode_q       <= bus.mode_i;
                        busy_o_q     <= 1'b1;
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    acc_q   <= '0;
                    k_q     <= '0;
                    state_q <= mode_q[1] ? S_MAC : S_OUT;
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (k_q == LAST_K) begin
                        state_q <= S_OUT;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                S_OUT: begin
                    res_q     <= res_d;
                    res_sat_q <= res_sat_d;
                    res_vld_q <= 1'b1;
                    wp_q      <= (wp_q == LAST_K) ? '0 : wp_q + AW'(1);
                    busy_o_q  <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.data_o    = data_o_q;
    assign bus.valid_o   = valid_o_q;
    assign bus.busy_o    = busy_o_q;
    assign bus.sat_o     = sat_o_q;
    assign bus.overrun_o = overrun_o_q;
endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac (TAPS=4): reset, impulse, saturation, modes, overrun, reset mid-MAC.
module tb_fir_seq_mac;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
    localparam int unsigned TP = 4;
    localparam logic [1:0] M_ZERO   = 2'b00;
    localparam logic [1:0] M_BYPASS = 2'b01;
    localparam logic [1:0] M_FILTER = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    int   vcount  = 0;

    always #5 clk = ~clk;

    fir_seq_mac_if #(.DATA_W(DW), .COEF_W(CW), .TAPS(TP)) bus ();

    fir_seq_mac #(
        .DATA_W(DW), .COEF_W(CW), .TAPS(TP), .FRAC(15), .ACC_W(40)
    ) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    always @(posedge clk) begin
        #1;
        if (bus.valid_o === 1'b1) vcount++;
    end

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        bus.coef_we_i   = 1'b1;
        bus.coef_addr_i = 2'(a);
        bus.coef_i      = 16'(v);
        @(negedge clk);
        bus.coef_we_i   = 1'b0;
    endtask

    task automatic do_sample(input logic [1:0] m, input int d, output int lat, output int q, output logic s);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.data_i  = 16'(d);
        bus.mode_i  = m;
        @(negedge clk);
        bus.start_i = 1'b0;
        lat = 0;
        while (bus.valid_o !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        q = int'(bus.data_o);
        s = bus.sat_o;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.data_o !== 16'sd0) $display("FAIL reset_data: got %0d expected 0", bus.data_o);
        else n_pass++;
        n_total++;
        if (bus.valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid_o);
        else n_pass++;
        n_total++;
        if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy_o);
        else n_pass++;
        n_total++;
        if (bus.sat_o !== 1'b0) $display("FAIL reset_sat: got %b expected 0", bus.sat_o);
        else n_pass++;
        n_total++;
        if (bus.overrun_o !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", bus.overrun_o);
        else n_pass++;
    endtask

    task automatic test_impulse(input string tag, input int e0, input int e1, input int e2);
        int ins [5];
        int exp [5];
        int lat, q;
        logic s;
        ins = '{1000, 0, 0, 0, 0};
        exp = '{e0, e1, e2, 0, 0};
        for (int i = 0; i < 5; i++) begin
            do_sample(M_FILTER, ins[i], lat, q, s);
            n_total++;
            if (q !== exp[i]) $display("FAIL %s_data[%0d]: got %0d expected %0d", tag, i, q, exp[i]);
            else n_pass++;
            n_total++;
            if (lat !== 7) $display("FAIL %s_latency[%0d]: got %0d expected 7", tag, i, lat);
            else n_pass++;
        end
    endtask

    task automatic test_saturation();
        int lat, q;
        logic s;
        for (int i = 0; i < 4; i++) write_coef(i, 32767);
        for (int i = 0; i < 4; i++) begin
            do_sample(M_FILTER, 32767, lat, q, s);
            if (i == 0) begin
                n_total++;
                if (q !== 32766 || s !== 1'b0) $display("FAIL sat_first: got %0d sat=%b expected 32766 sat=0", q, s);
                else n_pass++;
            end
        end
        n_total++;
        if (q !== 32767 || s !== 1'b1) $display("FAIL sat_pos: got %0d sat=%b expected 32767 sat=1", q, s);
        else n_pass++;
        for (int i = 0; i < 4; i++) do_sample(M_FILTER, -32768, lat, q, s);
        n_total++;
        if (q !== -32768 || s !== 1'b1) $display("FAIL sat_neg: got %0d sat=%b expected -32768 sat=1", q, s);
        else n_pass++;
    endtask

    task automatic test_modes();
        int lat, q;
        logic s;
        write_coef(0, 16384);
        write_coef(1, 0);
        write_coef(2, 16384);
        write_coef(3, 0);
        do_sample(M_BYPASS, -1234, lat, q, s);
        n_total++;
        if (q !== -1234 || lat !== 3 || s !== 1'b0)
            $display("FAIL bypass: got %0d lat=%0d sat=%b expected -1234 lat=3 sat=0", q, lat, s);
        else n_pass++;
        do_sample(M_ZERO, 2000, lat, q, s);
        n_total++;
        if (q !== 0 || lat !== 3 || s !== 1'b0)
            $display("FAIL zero: got %0d lat=%0d sat=%b expected 0 lat=3 sat=0", q, lat, s);
        else n_pass++;
        do_sample(M_FILTER, 600, lat, q, s);
        n_total++;
        if (q !== -317 || lat !== 7) $display("FAIL mode_history: got %0d lat=%0d expected -317 lat=7", q, lat);
        else n_pass++;
    endtask

    task automatic test_overrun();
        int v0, q, lat;
        logic s;
        n_total++;
        if (bus.overrun_o !== 1'b0) $display("FAIL overrun_pre: got %b expected 0", bus.overrun_o);
        else n_pass++;
        v0 = vcount;
        q  = -99999;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.data_i  = 16'sd100;
        bus.mode_i  = M_FILTER;
        @(negedge clk);
        bus.start_i = 1'b0;
        @(negedge clk);
        bus.start_i     = 1'b1;
        bus.data_i      = 16'sd7777;
        bus.coef_we_i   = 1'b1;
        bus.coef_addr_i = 2'd2;
        bus.coef_i      = 16'sd0;
        @(negedge clk);
        bus.start_i   = 1'b0;
        bus.coef_we_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid_o === 1'b1) q = int'(bus.data_o);
            @(negedge clk);
        end
        n_total++;
        if (bus.overrun_o !== 1'b1) $display("FAIL overrun_flag: got %b expected 1", bus.overrun_o);
        else n_pass++;
        n_total++;
        if (vcount - v0 !== 1) $display("FAIL overrun_valid_count: got %0d expected 1", vcount - v0);
        else n_pass++;
        n_total++;
        if (q !== 1050) $display("FAIL overrun_data: got %0d expected 1050", q);
        else n_pass++;
        do_sample(M_FILTER, 0, lat, q, s);
        n_total++;
        if (q !== 300) $display("FAIL overrun_wp_coef: got %0d expected 300", q);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mac();
        int v0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.data_i  = 16'sd1000;
        bus.mode_i  = M_FILTER;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (3) @(negedge clk);
        v0    = vcount;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.busy_o !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", bus.busy_o);
        else n_pass++;
        n_total++;
        if (bus.overrun_o !== 1'b0 || bus.data_o !== 16'sd0)
            $display("FAIL midreset_clear: got overrun=%b data=%0d expected 0/0", bus.overrun_o, bus.data_o);
        else n_pass++;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_total++;
        if (vcount !== v0) $display("FAIL midreset_no_valid: got %0d pulses expected 0", vcount - v0);
        else n_pass++;
        test_impulse("zero_coef", 0, 0, 0);
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.data_i      = '0;
        bus.mode_i      = '0;
        bus.coef_we_i   = 1'b0;
        bus.coef_addr_i = '0;
        bus.coef_i      = '0;
        test_reset();
        write_coef(0, 16384);
        write_coef(1, 8192);
        write_coef(2, -8192);
        write_coef(3, 0);
        test_impulse("impulse", 500, 250, -250);
        test_saturation();
        test_modes();
        test_overrun();
        test_reset_mid_mac();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
